// File: rtl/m68k_bus_pkg.sv
// Shared definitions for the 68000 bus bridge: FSM state encoding,
// 68000 function-code values and the default bus timeout.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_STROBE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam logic [2:0] FC_USER_DATA = 3'd1;
    localparam logic [2:0] FC_USER_PROG = 3'd2;
    localparam logic [2:0] FC_SUPV_DATA = 3'd5;
    localparam logic [2:0] FC_SUPV_PROG = 3'd6;
    localparam logic [2:0] FC_INT_ACK   = 3'd7;

    localparam int DEFAULT_TIMEOUT = 255;

    // Wait/release counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sync.sv
// Multi-stage synchroniser for an asynchronous level input; resets to the
// inactive (high) level so active-low bus handshakes read as idle.
module sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ff_q <= {STAGES{RESET_VAL}};
        else       ff_q <= ff_d;
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_bridge.sv
// Turns the core's held rd/wr request into an asynchronous 68000 bus cycle
// (AS/UDS/LDS/R_W out, DTACK/BERR in) with wait-state and timeout control.
module m68k_bus_bridge
    import m68k_bus_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_WAIT    = 0,
    parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [1:0]        req_be,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic [2:0]        req_fc,
    output logic              ack,
    output logic              berr,
    output logic              tmo,
    output logic [15:0]       rdata,
    output logic              busy,
    output logic [ADDR_W-2:0] addr,
    output logic [2:0]        FC,
    output logic              ASn,
    output logic              UDSn,
    output logic              LDSn,
    output logic              R_Wn,
    output logic [15:0]       data_out,
    output logic              data_oe,
    input  logic [15:0]       data_in,
    input  logic              DTACKn,
    input  logic              BERRn,
    output state_e            dbg_state
);

    // Request handshake: the core holds req_rd/req_wr (and its qualifiers) until
    // it sees the one-cycle ack pulse, then drops them; a request is only
    // accepted in IDLE and never in the cycle ack is showing.

    localparam logic [15:0] MIN_WAIT_C = 16'(MIN_WAIT);
    localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);

    state_e            state_q, state_d;
    logic              ack_q, ack_d, berr_q, berr_d, tmo_q, tmo_d, busy_q, busy_d;
    logic [15:0]       rdata_q, rdata_d, data_out_q, data_out_d, cnt_q, cnt_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [2:0]        fc_q, fc_d;
    logic [1:0]        be_q, be_d;
    logic              as_n_q, as_n_d, uds_n_q, uds_n_d, lds_n_q, lds_n_d;
    logic              rw_n_q, rw_n_d, data_oe_q, data_oe_d;
    logic              wait_exit;
    logic              dtack_n_s, berr_n_s;
    logic              unused_addr0;

    assign unused_addr0 = req_addr[0];

    sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_dtack (
        .clk(clk), .rstn(rstn), .d(DTACKn), .q(dtack_n_s)
    );
    sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_berr (
        .clk(clk), .rstn(rstn), .d(BERRn), .q(berr_n_s)
    );

    always_comb begin
        state_d    = state_q;
        ack_d      = 1'b0;
        berr_d     = 1'b0;
        tmo_d      = 1'b0;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        fc_d       = fc_q;
        be_d       = be_q;
        data_out_d = data_out_q;
        rw_n_d     = rw_n_q;
        as_n_d     = as_n_q;
        uds_n_d    = uds_n_q;
        lds_n_d    = lds_n_q;
        data_oe_d  = data_oe_q;
        cnt_d      = cnt_q;
        wait_exit  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!ack_q && (req_rd || req_wr)) begin
                    if (req_be == 2'b00) begin
                        ack_d = 1'b1;
                    end else begin
                        addr_d     = req_addr[ADDR_W-1:1];
                        fc_d       = req_fc;
                        be_d       = req_be;
                        data_out_d = req_wdata;
                        rw_n_d     = req_rd;
                        state_d    = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                as_n_d  = 1'b0;
                state_d = ST_STROBE;
                if (rw_n_q) begin
                    uds_n_d = ~be_q[1];
                    lds_n_d = ~be_q[0];
                end else begin
                    data_oe_d = 1'b1;
                end
            end
            ST_STROBE: begin
                // Write strobes trail data_oe by one cycle so data is on the bus first.
                if (!rw_n_q) begin
                    uds_n_d = ~be_q[1];
                    lds_n_d = ~be_q[0];
                end
                cnt_d   = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!berr_n_s) begin
                    wait_exit = 1'b1;
                    berr_d    = 1'b1;
                end else if (!dtack_n_s && (cnt_q >= MIN_WAIT_C)) begin
                    wait_exit = 1'b1;
                    if (rw_n_q) rdata_d = data_in;
                end else if (cnt_q == TIMEOUT_C) begin
                    wait_exit = 1'b1;
                    berr_d    = 1'b1;
                    tmo_d     = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
                if (wait_exit) begin
                    ack_d   = 1'b1;
                    as_n_d  = 1'b1;
                    uds_n_d = 1'b1;
                    lds_n_d = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                data_oe_d = 1'b0;
                if ((dtack_n_s && berr_n_s) || (cnt_q == TIMEOUT_C)) begin
                    rw_n_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            berr_q     <= 1'b0;
            tmo_q      <= 1'b0;
            busy_q     <= 1'b0;
            rdata_q    <= 16'd0;
            addr_q     <= '0;
            fc_q       <= 3'd0;
            be_q       <= 2'b00;
            data_out_q <= 16'd0;
            rw_n_q     <= 1'b1;
            as_n_q     <= 1'b1;
            uds_n_q    <= 1'b1;
            lds_n_q    <= 1'b1;
            data_oe_q  <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            berr_q     <= berr_d;
            tmo_q      <= tmo_d;
            busy_q     <= busy_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            fc_q       <= fc_d;
            be_q       <= be_d;
            data_out_q <= data_out_d;
            rw_n_q     <= rw_n_d;
            as_n_q     <= as_n_d;
            uds_n_q    <= uds_n_d;
            lds_n_q    <= lds_n_d;
            data_oe_q  <= data_oe_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ack       = ack_q;
    assign berr      = berr_q;
    assign tmo       = tmo_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign addr      = addr_q;
    assign FC        = fc_q;
    assign ASn       = as_n_q;
    assign UDSn      = uds_n_q;
    assign LDSn      = lds_n_q;
    assign R_Wn      = rw_n_q;
    assign data_out  = data_out_q;
    assign data_oe   = data_oe_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_m68k_bus_bridge.sv
// Directed bench for m68k_bus_bridge: a vector table of full bus cycles
// against a small slave model, plus reset, zero-byte-enable and mid-cycle reset sequences.
module tb_m68k_bus_bridge;
    import m68k_bus_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_rd, req_wr;
    logic [1:0]  req_be;
    logic [23:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_fc;
    logic        ack, berr, tmo, busy;
    logic [15:0] rdata;
    logic [22:0] addr;
    logic [2:0]  FC;
    logic        ASn, UDSn, LDSn, R_Wn;
    logic [15:0] data_out;
    logic        data_oe;
    logic [15:0] data_in;
    logic        DTACKn, BERRn;
    state_e      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    m68k_bus_bridge #(
        .ADDR_W(24), .SYNC_STAGES(2), .MIN_WAIT(0), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_rd(req_rd), .req_wr(req_wr), .req_be(req_be), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_fc(req_fc),
        .ack(ack), .berr(berr), .tmo(tmo), .rdata(rdata), .busy(busy),
        .addr(addr), .FC(FC), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .R_Wn(R_Wn),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .DTACKn(DTACKn), .BERRn(BERRn), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [23:0] addr;
        logic [2:0]  fc;
        logic [15:0] wdata;
        logic [15:0] din;
        int          dly;
        logic        slv_dtack;
        logic        slv_berr;
        int          exp_ack;
        logic        exp_berr;
        logic        exp_tmo;
        logic [15:0] exp_rdata;
        logic [22:0] exp_addr;
        int          exp_uds;
        int          exp_lds;
        logic        exp_rwn;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        req_be    = 2'b00;
        req_addr  = 24'h0;
        req_wdata = 16'h0;
        req_fc    = 3'd0;
        data_in   = 16'h0;
        DTACKn    = 1'b1;
        BERRn     = 1'b1;
    endtask

    // Drives one request from a negedge and plays the slave; cycle 1 is the
    // first cycle after the edge that samples the request.
    task automatic run_txn(input int idx, input vec_t v);
        int cyc = 0, ack_cyc = -1, ack_cnt = 0, berr_cnt = 0, tmo_cnt = 0;
        int asn_fall = -1, uds_first = -1, lds_first = -1, oe_first = -1, oe_last = -1;
        logic berr_at = 0, tmo_at = 0, asn_at = 0, rwn_seen = 1, done = 0;
        logic [15:0] rdata_at = 0, dout_seen = 0;
        logic [22:0] addr_seen = 0;
        logic [2:0]  fc_seen = 0;
        string tag;
        tag = $sformatf("v%0d", idx);

        req_rd = v.rd; req_wr = v.wr; req_be = v.be; req_addr = v.addr;
        req_fc = v.fc; req_wdata = v.wdata; data_in = v.din;
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ack) begin
                ack_cnt++;
                if (ack_cyc < 0) begin
                    ack_cyc = cyc; berr_at = berr; tmo_at = tmo;
                    rdata_at = rdata; asn_at = ASn;
                end
            end
            if (berr) berr_cnt++;
            if (tmo) tmo_cnt++;
            if (cyc == 1) begin addr_seen = addr; fc_seen = FC; end
            if (cyc == 2) begin rwn_seen = R_Wn; dout_seen = data_out; end
            if (!UDSn && uds_first < 0) uds_first = cyc;
            if (!LDSn && lds_first < 0) lds_first = cyc;
            if (data_oe) begin
                if (oe_first < 0) oe_first = cyc;
                oe_last = cyc;
            end
            if (!ASn && asn_fall < 0) asn_fall = cyc;
            if (asn_fall >= 0 && !ASn && cyc == asn_fall + v.dly) begin
                if (v.slv_dtack) DTACKn = 1'b0;
                if (v.slv_berr)  BERRn  = 1'b0;
            end
            if (asn_fall >= 0 && ASn) begin DTACKn = 1'b1; BERRn = 1'b1; end
            if (ack_cyc >= 0 && cyc == ack_cyc + 1) begin req_rd = 1'b0; req_wr = 1'b0; end
            if (ack_cyc >= 0 && cyc > ack_cyc + 1 && !busy) done = 1;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s_complete: bridge still busy after %0d cycles, expected idle", tag, cyc);
        end
        check({tag, "_asn_fall"}, asn_fall, 2);
        check({tag, "_ack_cycle"}, ack_cyc, v.exp_ack);
        check({tag, "_ack_count"}, ack_cnt, 1);
        check({tag, "_berr"}, {berr_at, 8'(berr_cnt)}, {v.exp_berr, 8'(v.exp_berr)});
        check({tag, "_tmo"}, {tmo_at, 8'(tmo_cnt)}, {v.exp_tmo, 8'(v.exp_tmo)});
        check({tag, "_rdata"}, rdata_at, v.exp_rdata);
        check({tag, "_addr"}, addr_seen, v.exp_addr);
        check({tag, "_fc"}, fc_seen, v.fc);
        check({tag, "_rwn"}, rwn_seen, v.exp_rwn);
        check({tag, "_uds_first"}, uds_first, v.exp_uds);
        check({tag, "_lds_first"}, lds_first, v.exp_lds);
        check({tag, "_asn_at_ack"}, asn_at, 1'b1);
        if (!v.exp_rwn) begin
            check({tag, "_oe_first"}, oe_first, 2);
            check({tag, "_oe_last"}, oe_last, v.exp_ack);
            check({tag, "_data_out"}, dout_seen, v.wdata);
        end else begin
            check({tag, "_oe_never"}, oe_first, -1);
        end
    endtask

    initial begin
        int acks, asn_low, busy_seen;

        vecs[0] = '{1, 0, 2'b11, 24'h000100, FC_USER_DATA, 16'h0000, 16'hA55A, 1, 1, 0, 6, 0, 0, 16'hA55A, 23'h000080, 2, 2, 1};
        vecs[1] = '{0, 1, 2'b10, 24'h001234, FC_USER_DATA, 16'hBEEF, 16'h0000, 1, 1, 0, 6, 0, 0, 16'hA55A, 23'h00091A, 3, -1, 0};
        vecs[2] = '{1, 0, 2'b01, 24'hFFFFFE, FC_SUPV_DATA, 16'h0000, 16'h1234, 0, 1, 0, 5, 0, 0, 16'h1234, 23'h7FFFFF, -1, 2, 1};
        vecs[3] = '{1, 0, 2'b11, 24'h000200, FC_SUPV_PROG, 16'h0000, 16'h5555, 0, 1, 1, 5, 1, 0, 16'h1234, 23'h000100, 2, 2, 1};
        vecs[4] = '{1, 0, 2'b10, 24'h000002, FC_USER_PROG, 16'h0000, 16'hC3C3, 3, 1, 0, 8, 0, 0, 16'hC3C3, 23'h000001, 2, -1, 1};
        vecs[5] = '{0, 1, 2'b01, 24'h800000, FC_SUPV_DATA, 16'h0F0F, 16'h0000, 0, 1, 0, 5, 0, 0, 16'hC3C3, 23'h400000, -1, 3, 0};
        vecs[6] = '{1, 0, 2'b11, 24'h000010, FC_INT_ACK,   16'h0000, 16'hDEAD, 0, 0, 0, 20, 1, 1, 16'hC3C3, 23'h000008, 2, 2, 1};
        vecs[7] = '{0, 1, 2'b11, 24'h000ABC, FC_USER_DATA, 16'h1357, 16'h0000, 2, 0, 1, 7, 1, 0, 16'hC3C3, 23'h00055E, 3, 3, 0};
        vecs[8] = '{1, 1, 2'b11, 24'h000004, FC_USER_DATA, 16'hFFFF, 16'h7E7E, 0, 1, 0, 5, 0, 0, 16'h7E7E, 23'h000002, 2, 2, 1};
        vecs[9] = '{1, 0, 2'b11, 24'h000020, FC_USER_DATA, 16'h0000, 16'h9999, 2, 1, 0, 7, 0, 0, 16'h9999, 23'h000010, 2, 2, 1};

        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_strobes", {ASn, UDSn, LDSn, R_Wn}, 4'hF);
        check("reset_pulses", {data_oe, ack, berr, tmo, busy}, 5'b0);
        check("reset_addr_fc", {addr, FC}, 26'h0);
        check("reset_data", {data_out, rdata}, 32'h0);
        check("reset_state", dbg_state, ST_IDLE);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_txn(i, vecs[i]);
            @(negedge clk);
        end

        // zero byte enables: ack next cycle, no bus cycle, no retrigger
        req_rd = 1'b1; req_be = 2'b00; req_addr = 24'h000300;
        acks = 0; asn_low = 0; busy_seen = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) check("be00_ack_next", ack, 1'b1);
            if (ack) acks++;
            if (!ASn) asn_low++;
            if (busy) busy_seen++;
            if (c == 2) req_rd = 1'b0;
        end
        check("be00_ack_count", acks, 1);
        check("be00_asn_low", asn_low, 0);
        check("be00_busy", busy_seen, 0);
        check("be00_rdata", rdata, 16'h7E7E);

        // asynchronous reset in the middle of a write WAIT
        req_wr = 1'b1; req_be = 2'b11; req_addr = 24'h000040; req_wdata = 16'hAAAA;
        repeat (5) @(negedge clk);
        check("midrst_pre_oe_ds", {data_oe, UDSn, LDSn, ASn}, 4'b1000);
        #1 rstn = 1'b0;
        #1;
        check("midrst_strobes", {ASn, UDSn, LDSn}, 3'b111);
        check("midrst_oe_busy", {data_oe, busy}, 2'b00);
        check("midrst_rdata", rdata, 16'h0);
        req_wr = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_txn(9, vecs[9]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m68k_bus_bridge.md
# m68k_bus_bridge

Converts the single-clock request/acknowledge bus of the soft 68000 core (rd/wr enable, byte enables, held until acknowledge) into a true asynchronous 68000 bus cycle (ASn, UDSn, LDSn, R_Wn, DTACKn, BERRn) for external glue logic and SRAM. It sits between the core and the board-level m68k glue block, replacing ad-hoc enable-to-strobe assignments. Beyond strobe generation, it adds:
- configurable address width,
- DTACK/BERR synchronisation,
- minimum wait states,
- bus-timeout error,
- strobe-negation handshake.

## Interface
Parameters:
- ADDR_W, 24, byte-address width; bus address is ADDR_W-1 bits (A[ADDR_W-1:1])
- SYNC_STAGES, 2, flop stages on DTACKn and BERRn (>=2)
- MIN_WAIT, 0, minimum WAIT cycles before DTACK is honoured (0..255)
- TIMEOUT, 255, WAIT/RELEASE cycle limit (1..65535)

Ports (one clock `clk`; reset `rstn` is asynchronous, active-low):
- clk  in  1  bus clock (CLK68000)
- rstn  in  1  asynchronous active-low reset
- req_rd  in  1  read request, held until ack
- req_wr  in  1  write request, held until ack
- req_be  in  2  byte enables {upper, lower}
- req_addr  in  ADDR_W  byte address (bit 0 ignored)
- req_wdata  in  16  write data
- req_fc  in  3  function code
- ack  out  1  one-cycle completion pulse
- berr  out  1  one-cycle error pulse, coincident with ack
- tmo  out  1  one-cycle pulse, coincident with berr when cause is timeout
- rdata  out  16  read data, valid from ack until next read ack
- busy  out  1  high whenever state != IDLE
- addr  out  ADDR_W-1  bus address A[ADDR_W-1:1]
- FC  out  3  bus function code
- ASn, UDSn, LDSn, R_Wn  out  1 each  bus strobes
- data_out  out  16  write data to bus
- data_oe  out  1  drive enable for data_out
- data_in  in  16  read data from bus
- DTACKn  in  1  asynchronous data acknowledge
- BERRn  in  1  asynchronous bus error

## Operation
- States: IDLE, ADDR, STROBE, WAIT, RELEASE. All outputs are registered.
- **IDLE:** sample requests.
  - req_rd has priority over req_wr.
  - On a request, latch addr, fc, be, wdata and R_Wn (0 for write); go to ADDR.
  - If req_be==00: no bus cycle; pulse ack next cycle, rdata unchanged, stay IDLE.
  - Requests are ignored outside IDLE.
- **ADDR:** addr/FC/R_Wn valid, ASn high → STROBE.
- **STROBE:** ASn low.
  - Read: UDSn/LDSn low per be.
  - Write: data_oe=1, data strobes still high.
  - Clear wait counter → WAIT.
- **WAIT:** write data strobes go low on the first WAIT cycle. Each cycle, in priority order:
  1. Synced BERRn low → error exit.
  2. Synced DTACKn low and cnt>=MIN_WAIT → good exit; capture data_in into rdata on reads.
  3. cnt==TIMEOUT → error exit with tmo.
  4. Otherwise cnt++.
- **Any exit from WAIT:** pulse ack (plus berr/tmo on error); go to RELEASE with ASn, UDSn and LDSn high.
- **RELEASE:**
  - data_oe stays high for the first RELEASE cycle (write hold), then drops.
  - Wait for synced DTACKn high and BERRn high, or TIMEOUT cycles, then go to IDLE (no further error).
- Counter is 16 bits and saturates; it never wraps.
- Reset (asynchronous, including mid-cycle): state IDLE, ASn/UDSn/LDSn/R_Wn=1, data_oe=0, ack/berr/tmo/busy=0, addr/FC/data_out/rdata=0.

## Timing
- A request sampled in IDLE at cycle 0 produces:
  - ADDR at cycle 1,
  - ASn low at cycle 2,
  - first WAIT at cycle 3,
  - earliest ack at cycle 4 (DTACKn low ≥ SYNC_STAGES cycles before, MIN_WAIT=0).
- Each MIN_WAIT cycle adds one cycle to ack.
- Synchronisation adds SYNC_STAGES cycles of DTACK response latency.
- The master drops its request in the cycle after ack. The bridge never re-triggers, because it is in RELEASE.
- Minimum back-to-back request-to-request spacing is 6 cycles with a prompt slave.
- DTACKn still low at timeout expiry in RELEASE: go to IDLE anyway.

## Structure
- Shared package m68k_bus_pkg holds:
  - the state encoding,
  - FC constants (user/supervisor data/program, interrupt acknowledge),
  - the default TIMEOUT.
- Sub-module: the existing `sync` synchroniser, parametrised by stage count, instantiated twice (DTACKn, BERRn).

## Test plan
- Read, slave asserts DTACKn 1 cycle after ASn low, data_in=16'hA55A, be=11 → ack once, rdata=16'hA55A, UDSn=LDSn=0 during cycle, ASn high the cycle after ack.
- Write addr=24'h00_1234, be=10, wdata=16'hBEEF → addr=23'h091A, R_Wn=0, data_oe high from STROBE through first RELEASE cycle, UDSn low only after data_oe, LDSn stays high.
- DTACKn never asserted, TIMEOUT=16 → ack+berr+tmo pulse exactly 17 WAIT cycles after entry, bridge returns to IDLE.
- BERRn and DTACKn asserted together → berr=1, tmo=0, rdata unchanged.
- req_be=00 → ack next cycle, ASn never leaves 1.
- rstn low mid-WAIT → ASn/UDSn/LDSn high and data_oe low immediately (before next clk), busy=0; a following read completes normally.
